// File: rtl/dfe_stage_monitor_if.sv
// Bundle between the DFE stage outputs / debug host and dfe_stage_monitor.
// The master drives stage samples and control; the slave returns monitor, flag, counter and readback state.
interface dfe_stage_monitor_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_SRC    = 6,
  parameter int DEPTH      = 64,
  parameter int CNT_WIDTH  = 16
);
  localparam int SEL_W = $clog2(NUM_SRC);
  localparam int AW    = $clog2(DEPTH);

  logic [NUM_SRC-1:0][DATA_WIDTH-1:0] src_data;
  logic [NUM_SRC-1:0]                 src_valid;
  logic [NUM_SRC-1:0]                 src_ovf;
  logic [NUM_SRC-1:0]                 src_unf;
  logic [SEL_W-1:0]                   sel;
  logic                               trig_mode;
  logic [AW:0]                        cap_len;
  logic                               arm;
  logic                               abort;
  logic [NUM_SRC-1:0]                 flag_clr;
  logic                               evt_clr;
  logic                               rd_en;
  logic [AW-1:0]                      rd_addr;
  logic [DATA_WIDTH-1:0]              rd_data;
  logic                               rd_valid;
  logic [DATA_WIDTH-1:0]              mon_out;
  logic                               mon_valid;
  logic [NUM_SRC-1:0]                 sticky_ovf;
  logic [NUM_SRC-1:0]                 sticky_unf;
  logic [CNT_WIDTH-1:0]               evt_cnt;
  logic [1:0]                         state;
  logic [AW:0]                        cap_count;

  modport master (
    output src_data, src_valid, src_ovf, src_unf, sel, trig_mode, cap_len,
           arm, abort, flag_clr, evt_clr, rd_en, rd_addr,
    input  rd_data, rd_valid, mon_out, mon_valid, sticky_ovf, sticky_unf,
           evt_cnt, state, cap_count
  );

  modport slave (
    input  src_data, src_valid, src_ovf, src_unf, sel, trig_mode, cap_len,
           arm, abort, flag_clr, evt_clr, rd_en, rd_addr,
    output rd_data, rd_valid, mon_out, mon_valid, sticky_ovf, sticky_unf,
           evt_cnt, state, cap_count
  );
endinterface

// File: rtl/dfe_stage_monitor.sv
// DFE debug block: observation mux, sticky ovf/unf flags, saturating event counter, triggered capture buffer.
// Monitor and readback are 1-cycle registered; no backpressure, every selected strobe is taken.
module dfe_stage_monitor #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_SRC    = 6,
  parameter int DEPTH      = 64,
  parameter int CNT_WIDTH  = 16
) (
  input logic                clk,
  input logic                rst_n,
  dfe_stage_monitor_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_SRC);
  localparam int AW    = $clog2(DEPTH);
  localparam int NP    = 1 << SEL_W;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_ARMED   = 2'b01;
  localparam logic [1:0] ST_CAPTURE = 2'b10;
  localparam logic [1:0] ST_DONE    = 2'b11;

  localparam logic [AW:0]    DEPTH_V = (AW+1)'(DEPTH);
  localparam logic [SEL_W:0] NSRC_V  = (SEL_W+1)'(NUM_SRC);

  // Pad the sources up to a power of two so any select value indexes safely.
  logic [NP-1:0][DATA_WIDTH-1:0] data_ext;
  logic [NP-1:0]                 vld_ext;
  logic [NP-1:0]                 evt_ext;

  for (genvar g = 0; g < NP; g++) begin : g_ext
    if (g < NUM_SRC) begin : g_src
      assign data_ext[g] = bus.src_data[g];
      assign vld_ext[g]  = bus.src_valid[g];
      assign evt_ext[g]  = bus.src_ovf[g] | bus.src_unf[g];
    end else begin : g_pad
      assign data_ext[g] = '0;
      assign vld_ext[g]  = 1'b0;
      assign evt_ext[g]  = 1'b0;
    end
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [DATA_WIDTH-1:0] mon_q;
  logic                  mon_vld_q;
  logic [NUM_SRC-1:0]    sticky_ovf_q;
  logic [NUM_SRC-1:0]    sticky_unf_q;
  logic [CNT_WIDTH-1:0]  evt_q;
  logic [DATA_WIDTH-1:0] rd_q;
  logic                  rd_vld_q;
  logic [1:0]            st_q;
  logic [AW-1:0]         ptr_q;
  logic [AW:0]           cnt_q;
  logic [AW:0]           len_q;
  logic [SEL_W-1:0]      cap_sel_q;

  logic          sel_ok;
  logic [AW:0]   eff_len;
  logic [AW:0]   cnt_nxt;
  logic          wr_en;

  assign sel_ok  = {1'b0, bus.sel} < NSRC_V;
  assign eff_len = (bus.cap_len == '0 || bus.cap_len > DEPTH_V) ? DEPTH_V : bus.cap_len;
  assign cnt_nxt = cnt_q + 1'b1;

  // ARMED only writes the triggering sample; ptr is already 0 there.
  always_comb begin
    wr_en = 1'b0;
    if (rst_n && !bus.abort) begin
      if (st_q == ST_ARMED)
        wr_en = vld_ext[cap_sel_q] & evt_ext[cap_sel_q];
      else if (st_q == ST_CAPTURE)
        wr_en = vld_ext[cap_sel_q];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[ptr_q] <= data_ext[cap_sel_q];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mon_q        <= '0;
      mon_vld_q    <= 1'b0;
      sticky_ovf_q <= '0;
      sticky_unf_q <= '0;
      evt_q        <= '0;
      rd_q         <= '0;
      rd_vld_q     <= 1'b0;
      st_q         <= ST_IDLE;
      ptr_q        <= '0;
      cnt_q        <= '0;
      len_q        <= '0;
      cap_sel_q    <= '0;
    end else begin
      if (sel_ok)
        mon_q <= data_ext[bus.sel];
      mon_vld_q <= sel_ok & vld_ext[bus.sel];

      sticky_ovf_q <= (sticky_ovf_q & ~bus.flag_clr) | bus.src_ovf;
      sticky_unf_q <= (sticky_unf_q & ~bus.flag_clr) | bus.src_unf;

      if (bus.evt_clr)
        evt_q <= '0;
      else if (evt_ext[bus.sel] && evt_q != '1)
        evt_q <= evt_q + 1'b1;

      rd_vld_q <= bus.rd_en;
      if (bus.rd_en)
        rd_q <= mem[bus.rd_addr];

      case (st_q)
        ST_IDLE, ST_DONE: begin
          if (bus.arm && bus.abort) begin
            st_q <= ST_IDLE;
          end else if (bus.arm) begin
            cnt_q     <= '0;
            ptr_q     <= '0;
            len_q     <= eff_len;
            cap_sel_q <= bus.sel;
            st_q      <= bus.trig_mode ? ST_ARMED : ST_CAPTURE;
          end
        end
        ST_ARMED, ST_CAPTURE: begin
          if (bus.abort) begin
            st_q <= ST_IDLE;
          end else if (wr_en) begin
            ptr_q <= ptr_q + 1'b1;
            cnt_q <= cnt_nxt;
            st_q  <= (cnt_nxt == len_q) ? ST_DONE : ST_CAPTURE;
          end
        end
        default: st_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.mon_out    = mon_q;
  assign bus.mon_valid  = mon_vld_q;
  assign bus.sticky_ovf = sticky_ovf_q;
  assign bus.sticky_unf = sticky_unf_q;
  assign bus.evt_cnt    = evt_q;
  assign bus.rd_data    = rd_q;
  assign bus.rd_valid   = rd_vld_q;
  assign bus.state      = st_q;
  assign bus.cap_count  = cnt_q;
endmodule
